ap_txn_recorder: RTL and testbench
==================================

Name: ap_txn_recorder

Overview:
- Synthesizable per-module transaction recorder on the ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue) of one HLS module instance, e.g. the hart or an ALU op function.
- Pairs each accepted start with its done and emits timestamped latency records over a valid/ready stream.
- Sits directly upstream of the module-status monitoring/dump stage: one instance per monitored module, and the monitor drains the records.
- On finish it stops capturing, flushes its output, and raises drained.

Parameters:
- TS_W, 32, width of the free-running cycle timestamp and of the latency field.
- ID_W, 16, width of the transaction sequence number.
- START_DEPTH, 4, outstanding-start queue depth. Power of two, ≥2; bounds overlap for pipelined modules.
- OUT_DEPTH, 8, output record FIFO depth. Power of two, ≥2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  module start.
- ap_ready  in  1  module ready: input accepted.
- ap_done  in  1  module done.
- ap_continue  in  1  downstream continue; tie 1'b1 when unused.
- finish  in  1  end of run; sticky once sampled.
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_id  out  ID_W  sequence number of the completed transaction.
- rec_start_ts  out  TS_W  timestamp of start acceptance.
- rec_done_ts  out  TS_W  timestamp of done.
- rec_latency  out  TS_W  rec_done_ts − rec_start_ts, mod 2^TS_W.
- ovf_start  out  1  sticky: start dropped, queue full.
- ovf_out  out  1  sticky: record dropped, output FIFO full.
- orphan_done  out  1  sticky: done with no outstanding start.
- drained  out  1  finish seen and output FIFO empty.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - Timestamp, ID counter, both queues and all sticky flags cleared; state RUN.
  - Assertion mid-operation discards every pending start and record immediately; nothing is flushed.
- Timestamp:
  - ts increments by 1 every clock edge while reset=1.
  - First cycle after reset release has ts=0.
  - Wraps at 2^TS_W.
- Start event: ap_start&&ap_ready sampled high in RUN.
  - Pushes current ts into the start queue.
  - If the queue is full: drop the start, set ovf_start; ID is not consumed.
- Done event: ap_done&&ap_continue sampled high in RUN.
  - Pops the oldest start_ts and forms {rec_id=id_ctr, start_ts, done_ts=ts, latency}.
  - id_ctr increments, wrapping at 2^ID_W.
  - If the output FIFO is full: drop the record, set ovf_out, still pop the start and still increment id_ctr.
- Same-cycle start and done:
  - Pop is processed before push, so a full start queue accepts the new start.
  - With an empty start queue, the done pairs with the same-cycle start (bypass): latency 0, start queue stays empty.
- Done with an empty start queue and no same-cycle start: set orphan_done, no record, id_ctr unchanged.
- Output FIFO:
  - First-word-fall-through, registered.
  - rec_valid rises the cycle after the done edge; records are visible one cycle after capture.
  - Transfer occurs when rec_valid&&rec_ready.
  - Fields hold stable while rec_valid=1 and rec_ready=0.
  - Simultaneous push and pop when full is legal and counts as not full: no drop.
- State machine (states RUN, DRAIN, DONE):
  - RUN → DRAIN when finish=1 is sampled.
    - A start or done event on that same edge is still captured.
    - From the next edge, events are ignored; no flag updates.
    - Outstanding starts are discarded.
  - DRAIN → DONE when the output FIFO is empty. This can be the same edge if already empty.
  - DONE: drained=1. Stays in DONE until reset; finish deasserting has no effect.
- Sticky flags clear only on reset.

Test Plan:
- Single transaction:
  - Stimulus: reset release; start accepted at ts=5; done at ts=12; rec_ready=1.
  - Response: rec_valid=1 at ts=13 with id=0, start=5, done=12, latency=7; pulses for 1 cycle.
- Pipelined overlap:
  - Stimulus: starts at ts=2,3,4,5; dones at ts=10,11,12,13.
  - Response: four records, ids 0..3, latency 8 each, in order; no flags.
- Overflow:
  - Stimulus: START_DEPTH=4; five starts with no done → ovf_start=1. Then rec_ready=0 and ten done/start pairs.
  - Response: exactly OUT_DEPTH=8 records held, ovf_out=1, and the next accepted record id reflects the dropped ones.
- Bypass and orphan:
  - Stimulus: empty queue, start+done same cycle at ts=20; separately a done with no start.
  - Response: first gives a record with latency 0; second sets orphan_done=1 with no record and id unchanged.
- Finish drain:
  - Stimulus: 3 records buffered, rec_ready=0, finish=1; a start/done pulse 2 cycles later.
  - Response: pulse ignored; drained stays 0. Then rec_ready=1 → 3 records out, drained=1 the cycle after the FIFO empties.
- Async reset mid-run:
  - Stimulus: reset=0 between clock edges with 2 records pending.
  - Response: rec_valid and all flags drop immediately without a clock edge. After release: ts restarts at 0 and the next record has id=0.

Source files
------------

// File: rtl/ap_txn_recorder.sv
// ---------------------------------------------------------------------------
// ap_txn_recorder
//
// Transaction recorder for the ap_ctrl handshake of a single HLS module
// instance. Each accepted start (ap_start && ap_ready) is timestamped and
// queued. Each completion (ap_done && ap_continue) is paired with the oldest
// queued start, and the result goes out as a latency record on a
// valid/ready stream. When finish is seen, capture stops, the record FIFO
// drains, and drained is raised.
//
// Parameters
//   TS_W         width of the free-running timestamp and of the latency field
//   ID_W         width of the transaction sequence number
//   START_DEPTH  depth of the outstanding-start queue (power of two, >= 2)
//   OUT_DEPTH    depth of the output record FIFO (power of two, >= 2)
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   ap_start, ap_ready    start handshake of the monitored module
//   ap_done, ap_continue  done handshake of the monitored module
//   finish                end of run (sticky once sampled)
//   rec_valid/rec_ready   record stream handshake (first-word-fall-through)
//   rec_id, rec_start_ts, rec_done_ts, rec_latency   record fields
//   ovf_start, ovf_out, orphan_done                  sticky error flags
//   drained               finish seen and every record delivered
// ---------------------------------------------------------------------------
module ap_txn_recorder #(
    parameter int TS_W        = 32,
    parameter int ID_W        = 16,
    parameter int START_DEPTH = 4,
    parameter int OUT_DEPTH   = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ap_start,
    input  logic            ap_ready,
    input  logic            ap_done,
    input  logic            ap_continue,
    input  logic            finish,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [ID_W-1:0] rec_id,
    output logic [TS_W-1:0] rec_start_ts,
    output logic [TS_W-1:0] rec_done_ts,
    output logic [TS_W-1:0] rec_latency,
    output logic            ovf_start,
    output logic            ovf_out,
    output logic            orphan_done,
    output logic            drained
);

    localparam int SA_W = $clog2(START_DEPTH);
    localparam int OA_W = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] done_ts;
    } rec_t;

    state_t          state, state_nxt;
    logic [TS_W-1:0] ts;
    logic [ID_W-1:0] id_ctr;

    // Start queue: pointers carry one extra wrap bit to tell full from empty.
    logic [TS_W-1:0] sq_mem [START_DEPTH];
    logic [SA_W:0]   sq_rd, sq_wr;
    logic            sq_empty, sq_full;

    // Output record FIFO, same pointer scheme.
    rec_t            of_mem [OUT_DEPTH];
    logic [OA_W:0]   of_rd, of_wr, of_rd_nxt, of_wr_nxt;
    logic            of_full, of_empty_nxt;

    logic            run, start_ev, done_ev;
    logic            sq_pop, sq_push, bypass, orphan, start_drop;
    logic            rec_push, of_accept, of_pop, rec_drop;
    logic [TS_W-1:0] rec_start;
    rec_t            rec_new, rec_head;

    // ---------------------------------------------------------------- events
    assign run      = (state == RUN);
    assign start_ev = run && ap_start && ap_ready;
    assign done_ev  = run && ap_done && ap_continue;

    assign sq_empty = (sq_wr == sq_rd);
    assign sq_full  = (sq_wr[SA_W] != sq_rd[SA_W]) &&
                      (sq_wr[SA_W-1:0] == sq_rd[SA_W-1:0]);

    // A done pops before a same-cycle start pushes. So a full queue still
    // takes the new start, and an empty queue pairs the done directly with
    // the same-cycle start (bypass, latency 0).
    assign sq_pop     = done_ev && !sq_empty;
    assign bypass     = done_ev && sq_empty && start_ev;
    assign orphan     = done_ev && sq_empty && !start_ev;
    assign sq_push    = start_ev && !bypass && (!sq_full || sq_pop);
    assign start_drop = start_ev && sq_full && !sq_pop;

    assign rec_push  = sq_pop || bypass;
    assign rec_start = bypass ? ts : sq_mem[sq_rd[SA_W-1:0]];
    assign rec_new   = '{id: id_ctr, start_ts: rec_start, done_ts: ts};

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign of_full   = (of_wr[OA_W] != of_rd[OA_W]) &&
                       (of_wr[OA_W-1:0] == of_rd[OA_W-1:0]);
    assign of_pop    = rec_valid && rec_ready;
    assign of_accept = rec_push && (!of_full || of_pop);
    assign rec_drop  = rec_push && of_full && !of_pop;

    assign of_wr_nxt    = of_wr + (OA_W+1)'(of_accept);
    assign of_rd_nxt    = of_rd + (OA_W+1)'(of_pop);
    assign of_empty_nxt = (of_wr_nxt == of_rd_nxt);

    // ----------------------------------------------------------- state logic
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so a path that assigns nothing cannot infer a latch.
        state_nxt = state;
        case (state)
            RUN:     if (finish) state_nxt = of_empty_nxt ? DONE : DRAIN;
            DRAIN:   if (of_empty_nxt) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    // ------------------------------------------------------- control registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            ts          <= '0;
            id_ctr      <= '0;
            sq_rd       <= '0;
            sq_wr       <= '0;
            of_rd       <= '0;
            of_wr       <= '0;
            ovf_start   <= 1'b0;
            ovf_out     <= 1'b0;
            orphan_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register here samples the values from before the edge.
            state <= state_nxt;
            ts    <= ts + TS_W'(1);
            of_wr <= of_wr_nxt;
            of_rd <= of_rd_nxt;

            // A dropped record still uses up its sequence number.
            if (rec_push) id_ctr <= id_ctr + ID_W'(1);

            // On the finish edge, events are still captured, but every start
            // that is still outstanding is thrown away.
            if (run && finish) begin
                sq_rd <= '0;
                sq_wr <= '0;
            end else begin
                if (sq_pop)  sq_rd <= sq_rd + (SA_W+1)'(1);
                if (sq_push) sq_wr <= sq_wr + (SA_W+1)'(1);
            end

            if (start_drop) ovf_start   <= 1'b1;
            if (rec_drop)   ovf_out     <= 1'b1;
            if (orphan)     orphan_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------- storage
    // NOTE: the storage arrays have no reset. Resetting the pointers makes
    // stale contents unreachable, and the output fields are gated by
    // rec_valid, so no stale entry ever appears on the ports.
    always_ff @(posedge clock) begin
        if (sq_push)   sq_mem[sq_wr[SA_W-1:0]] <= ts;
        if (of_accept) of_mem[of_wr[OA_W-1:0]] <= rec_new;
    end

    // ------------------------------------------------------------- outputs
    assign rec_valid    = (of_wr != of_rd);
    assign rec_head     = of_mem[of_rd[OA_W-1:0]];
    assign rec_id       = rec_valid ? rec_head.id       : '0;
    assign rec_start_ts = rec_valid ? rec_head.start_ts : '0;
    assign rec_done_ts  = rec_valid ? rec_head.done_ts  : '0;
    assign rec_latency  = rec_valid ? (rec_head.done_ts - rec_head.start_ts) : '0;
    assign drained      = (state == DONE);

endmodule

// File: tb/tb_ap_txn_recorder.sv
// ---------------------------------------------------------------------------
// tb_ap_txn_recorder
//
// Directed bench for ap_txn_recorder. The stimulus process pushes each
// expected record into a scoreboard queue at the moment it issues the done.
// A monitor running on the falling clock edge pops the queue and compares
// whenever a record transfers (rec_valid && rec_ready). Flag, timing and
// drain behaviour are checked inline by the stimulus process.
// The local variable 'now' holds the ts value the next rising edge samples.
// ---------------------------------------------------------------------------
module tb_ap_txn_recorder;

    localparam int TS_W        = 32;
    localparam int ID_W        = 16;
    localparam int START_DEPTH = 4;
    localparam int OUT_DEPTH   = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            ap_start = 1'b0, ap_ready = 1'b1;
    logic            ap_done = 1'b0, ap_continue = 1'b1;
    logic            finish = 1'b0;
    logic            rec_valid, rec_ready = 1'b0;
    logic [ID_W-1:0] rec_id;
    logic [TS_W-1:0] rec_start_ts, rec_done_ts, rec_latency;
    logic            ovf_start, ovf_out, orphan_done, drained;

    ap_txn_recorder #(
        .TS_W(TS_W), .ID_W(ID_W), .START_DEPTH(START_DEPTH), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_id(rec_id), .rec_start_ts(rec_start_ts),
        .rec_done_ts(rec_done_ts), .rec_latency(rec_latency),
        .ovf_start(ovf_start), .ovf_out(ovf_out),
        .orphan_done(orphan_done), .drained(drained)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] s;
        logic [TS_W-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   now   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares each record that transfers.
    always @(negedge clock) begin
        if (reset && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_record: got id %0d start %0d done %0d, expected none",
                         rec_id, rec_start_ts, rec_done_ts);
            end else begin
                exp_t e;
                logic [TS_W-1:0] lat;
                e   = exp_q.pop_front();
                lat = e.d - e.s;
                check("rec_id",       rec_id,       e.id);
                check("rec_start_ts", rec_start_ts, e.s);
                check("rec_done_ts",  rec_done_ts,  e.d);
                check("rec_latency",  rec_latency,  lat);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        now++;
    endtask

    task automatic wait_ts(input int t);
        while (now < t) step();
    endtask

    // Hold start/done for exactly the edge that samples ts == t.
    task automatic ev(input int t, input logic s, input logic d);
        wait_ts(t);
        ap_start = s;
        ap_done  = d;
        step();
        ap_start = 1'b0;
        ap_done  = 1'b0;
    endtask

    task automatic expect_rec(input int id, input int s, input int d);
        exp_t e;
        e.id = ID_W'(id);
        e.s  = TS_W'(s);
        e.d  = TS_W'(d);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset     = 1'b0;
        ap_start  = 1'b0;
        ap_done   = 1'b0;
        finish    = 1'b0;
        rec_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        now   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state
        #2;
        check("rst_rec_valid",   rec_valid,   0);
        check("rst_rec_latency", rec_latency, 0);
        check("rst_flags",       {ovf_start, ovf_out, orphan_done, drained}, 0);

        // ---------------- single transaction
        do_reset();
        rec_ready = 1'b1;
        ev(5, 1'b1, 1'b0);
        expect_rec(0, 5, 12);
        ev(12, 1'b0, 1'b1);
        check("t1_valid_at_13", rec_valid, 1);
        step();
        check("t1_valid_pulse", rec_valid, 0);

        // ---------------- pipelined overlap
        do_reset();
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) ev(2 + i, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_rec(i, 2 + i, 10 + i);
            ev(10 + i, 1'b0, 1'b1);
        end
        step();
        step();
        check("t2_no_flags", {ovf_start, ovf_out, orphan_done}, 0);
        check("t2_all_seen", exp_q.size(), 0);

        // ---------------- overflow of both queues
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ev(1 + i, 1'b1, 1'b0);
            if (i == 3) check("t3_ovf_start_at_depth", ovf_start, 0);
        end
        check("t3_ovf_start", ovf_start, 1);
        // Queue holds starts 1..4; each pair pops the oldest and pushes ts.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_rec(i, (i < 4) ? (1 + i) : (6 + i), 10 + i);
            ev(10 + i, 1'b1, 1'b1);
            if (i == 7) check("t3_ovf_out_when_full", ovf_out, 0);
        end
        check("t3_ovf_out",   ovf_out,   1);
        check("t3_hold_head", rec_id,    0);
        rec_ready = 1'b1;
        wait_ts(29);
        check("t3_exactly8",   rec_valid,    0);
        check("t3_all_seen",   exp_q.size(), 0);
        // Records 8 and 9 were dropped; the queue still holds starts 16..19.
        expect_rec(10, 16, 30);
        ev(30, 1'b0, 1'b1);
        step();
        step();
        check("t3_next_id_seen", exp_q.size(), 0);

        // ---------------- bypass and orphan
        do_reset();
        rec_ready = 1'b1;
        expect_rec(0, 20, 20);
        ev(20, 1'b1, 1'b1);
        step();
        check("t4_no_orphan_yet", orphan_done, 0);
        ev(25, 1'b0, 1'b1);
        step();
        check("t4_orphan",      orphan_done, 1);
        check("t4_orphan_norec", rec_valid,  0);
        ev(27, 1'b1, 1'b0);
        expect_rec(1, 27, 30);
        ev(30, 1'b0, 1'b1);
        step();
        step();
        check("t4_all_seen", exp_q.size(), 0);

        // ---------------- finish and drain
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) ev(1 + i, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_rec(i, 1 + i, 5 + i);
            ev(5 + i, 1'b0, 1'b1);
        end
        ev(8, 1'b1, 1'b0);
        wait_ts(10);
        finish = 1'b1;
        step();
        ev(12, 1'b1, 1'b1);
        ev(13, 1'b0, 1'b1);
        check("t5_drained_held", drained,     0);
        check("t5_records_held", rec_valid,   1);
        check("t5_no_orphan",    orphan_done, 0);
        wait_ts(15);
        rec_ready = 1'b1;
        step();
        check("t5_drained_mid", drained, 0);
        wait_ts(20);
        check("t5_fifo_empty", rec_valid,    0);
        check("t5_drained",    drained,      1);
        check("t5_all_seen",   exp_q.size(), 0);
        finish = 1'b0;
        ev(21, 1'b1, 1'b1);
        step();
        check("t5_drained_sticky",  drained,   1);
        check("t5_done_ignores_ev", rec_valid, 0);

        // ---------------- async reset mid-run
        do_reset();
        rec_ready = 1'b0;
        ev(1, 1'b1, 1'b0);
        ev(2, 1'b1, 1'b0);
        ev(4, 1'b0, 1'b1);
        ev(5, 1'b0, 1'b1);
        ev(6, 1'b0, 1'b1);
        step();
        check("t6_pending",     rec_valid,   1);
        check("t6_orphan_set",  orphan_done, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_valid",  rec_valid,   0);
        check("t6_async_orphan", orphan_done, 0);
        check("t6_async_id",     rec_id,      0);
        exp_q.delete();
        step();
        reset     = 1'b1;
        now       = 0;
        rec_ready = 1'b1;
        ev(3, 1'b1, 1'b0);
        expect_rec(0, 3, 5);
        ev(5, 1'b0, 1'b1);
        step();
        step();
        check("t6_all_seen", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
